fifo_accu_selector: RTL

FIFO_ACCU_SELECTOR -- requirements
Module: fifo_accu_selector

---
 rtl/fifo_accu_selector.sv | 134 +++++++++++++
 1 files changed

// File: rtl/fifo_accu_selector.sv
// Bank of independent first-word-fall-through FIFOs sharing one write port.
// The write port can also pop a channel's head and push (head + addend) back to its tail.
module fifo_accu_selector #(
   parameter int CHANNEL_WIDTH = 32,
   parameter int CHANNEL_DEPTH = 128,
   parameter int CHANNELS_CNT  = 5,
   parameter bit SATURATE      = 1'b0
) (
   input  logic                                               clk,
   input  logic                                               rst_all,
   input  logic [CHANNELS_CNT-1:0]                            rst_channels,
   input  logic [$clog2(CHANNELS_CNT)-1:0]                    i_channel_wr_select,
   input  logic                                               i_wr_valid,
   input  logic [CHANNEL_WIDTH-1:0]                           i_wr_data,
   input  logic                                               i_wr_accumulate,
   input  logic [CHANNELS_CNT-1:0]                            i_rd_en_channels,
   output logic [CHANNELS_CNT-1:0]                            o_rd_valid_channels,
   output logic [CHANNELS_CNT-1:0][CHANNEL_WIDTH-1:0]         o_rd_data_channels,
   output logic [CHANNELS_CNT-1:0]                            o_ready_channels,
   output logic [CHANNELS_CNT-1:0]                            o_empty_channels,
   output logic [CHANNELS_CNT-1:0]                            o_full_channels,
   output logic [CHANNELS_CNT-1:0][$clog2(CHANNEL_DEPTH):0]   o_fill_count_channels,
   output logic                                               o_wr_overflow,
   output logic                                               o_acc_carry
);

   localparam int SEL_W = $clog2(CHANNELS_CNT);
   localparam int PTR_W = $clog2(CHANNEL_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   // NOTE: storage is never reset; pointers and counts alone define which entries are live.
   logic [CHANNEL_WIDTH-1:0] mem [CHANNELS_CNT][CHANNEL_DEPTH];

   logic [CHANNELS_CNT-1:0][PTR_W-1:0] rd_ptr, wr_ptr;
   logic [CHANNELS_CNT-1:0][CNT_W-1:0] count, count_next;
   logic [CHANNELS_CNT-1:0]            empty_q, full_q;
   logic                               wr_overflow_q, acc_carry_q;

   logic                       sel_ok;
   logic [CHANNELS_CNT-1:0]    ch_rst, wr_hit, rd_pop, pop, push;
   logic [CHANNEL_WIDTH-1:0]   head_sel, acc_value, push_data;
   logic [CHANNEL_WIDTH:0]     sum;
   logic                       carry, ovf_next, carry_next;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      sel_ok     = int'(i_channel_wr_select) < CHANNELS_CNT;
      head_sel   = '0;
      ovf_next   = i_wr_valid && !sel_ok;
      carry_next = 1'b0;
      ch_rst     = '0;
      wr_hit     = '0;
      rd_pop     = '0;
      pop        = '0;
      push       = '0;
      count_next = count;

      for (int k = 0; k < CHANNELS_CNT; k++) begin
         ch_rst[k] = rst_all | rst_channels[k];
         wr_hit[k] = i_wr_valid && sel_ok && (i_channel_wr_select == SEL_W'(k));
         if (wr_hit[k] && !empty_q[k]) head_sel = mem[k][rd_ptr[k]];
      end

      // An empty channel accumulates against an implicit zero head.
      sum       = {1'b0, head_sel} + {1'b0, i_wr_data};
      carry     = sum[CHANNEL_WIDTH];
      acc_value = (carry && SATURATE) ? '1 : sum[CHANNEL_WIDTH-1:0];
      push_data = i_wr_accumulate ? acc_value : i_wr_data;

      for (int k = 0; k < CHANNELS_CNT; k++) begin
         rd_pop[k] = i_rd_en_channels[k] & ~empty_q[k];
         if (wr_hit[k] && i_wr_accumulate) begin
            // The accumulate owns this channel's pop; a concurrent read request is ignored.
            pop[k]  = ~empty_q[k];
            push[k] = 1'b1;
            if (carry && !ch_rst[k]) carry_next = 1'b1;
         end else begin
            pop[k]  = rd_pop[k];
            push[k] = wr_hit[k] && (!full_q[k] || rd_pop[k]);
            if (wr_hit[k] && full_q[k] && !rd_pop[k] && !ch_rst[k]) ovf_next = 1'b1;
         end
         count_next[k] = count[k] + CNT_W'(push[k]) - CNT_W'(pop[k]);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      for (int k = 0; k < CHANNELS_CNT; k++) begin
         if (ch_rst[k]) begin
            rd_ptr[k]  <= '0;
            wr_ptr[k]  <= '0;
            count[k]   <= '0;
            empty_q[k] <= 1'b1;
            full_q[k]  <= 1'b0;
         end else begin
            if (pop[k])  rd_ptr[k] <= rd_ptr[k] + PTR_W'(1);
            if (push[k]) wr_ptr[k] <= wr_ptr[k] + PTR_W'(1);
            count[k]   <= count_next[k];
            empty_q[k] <= (count_next[k] == '0);
            full_q[k]  <= (count_next[k] == CNT_W'(CHANNEL_DEPTH));
         end
      end
      if (rst_all) begin
         wr_overflow_q <= 1'b0;
         acc_carry_q   <= 1'b0;
      end else begin
         wr_overflow_q <= ovf_next;
         acc_carry_q   <= carry_next;
      end
   end

   // On a full channel an accumulate writes the slot being popped, since wr_ptr == rd_ptr.
   always_ff @(posedge clk) begin
      for (int k = 0; k < CHANNELS_CNT; k++) begin
         if (push[k] && !ch_rst[k]) mem[k][wr_ptr[k]] <= push_data;
      end
   end

   always_comb begin
      o_rd_data_channels = '0;
      for (int k = 0; k < CHANNELS_CNT; k++) begin
         if (!empty_q[k]) o_rd_data_channels[k] = mem[k][rd_ptr[k]];
      end
   end

   assign o_rd_valid_channels   = ~empty_q;
   assign o_empty_channels      = empty_q;
   assign o_full_channels       = full_q;
   assign o_ready_channels      = ~full_q;
   assign o_fill_count_channels = count;
   assign o_wr_overflow         = wr_overflow_q;
   assign o_acc_carry           = acc_carry_q;

endmodule
